// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// The registered result drives the seven-segment scanner and holds steady between conversions.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = 8
) (
    input  logic                  clkin,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned ACC_W = 4 * (DIGITS + 2);
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [BIN_W-1:0]      r_sh;
    logic [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf;

    logic                  w_load;
    logic                  w_shift;
    logic                  w_last;
    logic                  w_busy;
    logic                  w_done;
    logic [ACC_W-1:0]      w_acc_corr;
    logic [ACC_W-1:0]      w_acc_next;
    logic [BIN_W-1:0]      w_sh_next;
    logic                  w_ovf_next;

    // Add-3 correction on every nibble in parallel, ahead of the shift.
    always_comb begin
        w_acc_corr = r_acc;
        for (int i = 0; i < int'(DIGITS + 2); i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_corr[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_acc_next = (w_acc_corr << 1) | ACC_W'(r_sh[BIN_W-1]);
    assign w_sh_next  = r_sh << 1;
    assign w_ovf_next = |w_acc_next[ACC_W-1:4*DIGITS];

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = StShift;
                end
            end
            StShift: begin
                w_busy  = 1'b1;
                w_shift = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_done = 1'b1;
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = StShift;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_sh  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_bcd <= '0;
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_sh  <= bin_in;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_sh  <= w_sh_next;
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            // Result is taken from the final shifted value on the edge entering DONE.
            if (w_last) begin
                r_bcd <= w_ovf_next ? {DIGITS{4'h9}} : w_acc_next[4*DIGITS-1:0];
                r_ovf <= w_ovf_next;
            end
        end
    end

    assign bcd_out = r_bcd;
    assign ovf     = r_ovf;
    assign busy    = w_busy;
    assign done    = w_done;

endmodule
